// File: rtl/tt_dfd_rr_onehot_arbiter.sv
// ---------------------------------------------------------------------------
// tt_dfd_rr_onehot_arbiter
//
// Round-robin arbiter for debug-trace sources. Once a multi-beat packet starts,
// the grant stays with that source until its last beat. The winning beat is
// captured in a one-entry output register. That register drives mux_en and
// the one-hot mux_sel, which feed a downstream decoded mux directly.
//
// Ports
//   clk      : clock
//   rst_n    : asynchronous active-low reset
//   in_vld   : per-source beat valid
//   in_last  : per-source last beat of packet (meaningful with in_vld)
//   in_rdy   : per-source accept, at most one bit high (combinational)
//   mux_en   : output register holds a beat
//   mux_sel  : one-hot source of the held beat, zero when mux_en=0
//   out_rdy  : downstream consumes the held beat this cycle
// ---------------------------------------------------------------------------
module tt_dfd_rr_onehot_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] in_vld,
  input  logic [NUM_REQ-1:0] in_last,
  output logic [NUM_REQ-1:0] in_rdy,
  output logic               mux_en,
  output logic [NUM_REQ-1:0] mux_sel,
  input  logic               out_rdy
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [PTR_W-1:0]   lock_owner;
  logic [PTR_W-1:0]   lock_owner_nxt;
  logic               mux_en_nxt;
  logic [NUM_REQ-1:0] mux_sel_nxt;

  logic               accept;
  logic               win_vld;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   cand;
  logic               take;

  // Source index reached by stepping off positions past base, modulo NUM_REQ.
  function automatic logic [PTR_W-1:0] rot_idx(input logic [PTR_W-1:0] base,
                                               input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[PTR_W-1:0];
  endfunction

  // Source index following w, wrapping from NUM_REQ-1 back to 0.
  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] w);
    if (w == PTR_W'(NUM_REQ - 1)) return '0;
    return w + PTR_W'(1);
  endfunction

  // The output register has room when it is empty or is being drained now.
  assign accept = !mux_en || out_rdy;

  // Winner search. While locked, only the owner can win. This holds even when
  // the owner has no valid beat: the bus then idles, and no one else gets it.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr;
    cand    = '0;
    if (state == LOCKED) begin
      win_vld = in_vld[lock_owner];
      win_idx = lock_owner;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = rot_idx(ptr, k);
        if (!win_vld && in_vld[cand]) begin
          win_vld = 1'b1;
          win_idx = cand;
        end
      end
    end
  end

  // rst_n gates the handshake so that no source sees in_rdy during reset.
  assign take = rst_n && accept && win_vld;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      lock_owner <= '0;
      mux_en     <= 1'b0;
      mux_sel    <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      lock_owner <= lock_owner_nxt;
      mux_en     <= mux_en_nxt;
      mux_sel    <= mux_sel_nxt;
    end
  end

  // Next-state logic. The pointer moves only on a last beat, so a packet in
  // progress never changes the round-robin order.
  always_comb begin
    state_nxt      = state;
    ptr_nxt        = ptr;
    lock_owner_nxt = lock_owner;
    mux_en_nxt     = mux_en;
    mux_sel_nxt    = mux_sel;
    if (take) begin
      mux_en_nxt           = 1'b1;
      mux_sel_nxt          = '0;
      mux_sel_nxt[win_idx] = 1'b1;
      if (in_last[win_idx]) begin
        state_nxt = IDLE;
        ptr_nxt   = next_idx(win_idx);
      end else begin
        state_nxt      = LOCKED;
        lock_owner_nxt = win_idx;
      end
    end else if (accept) begin
      mux_en_nxt  = 1'b0;
      mux_sel_nxt = '0;
    end
  end

  // Output logic
  always_comb begin
    in_rdy = '0;
    if (take) in_rdy[win_idx] = 1'b1;
  end

endmodule

// File: tb/tb_tt_dfd_rr_onehot_arbiter.sv
module tb_tt_dfd_rr_onehot_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] in_vld;
  logic [N-1:0] in_last;
  logic [N-1:0] in_rdy;
  logic         mux_en;
  logic [N-1:0] mux_sel;
  logic         out_rdy;

  int n_chk = 0;
  int n_err = 0;

  // Behavioural reference state, held as plain integers.
  int       m_ptr;
  int       m_owner;
  bit       m_locked;
  bit       m_en;
  logic [3:0] m_sel;

  tt_dfd_rr_onehot_arbiter #(.NUM_REQ(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (in_vld),
    .in_last (in_last),
    .in_rdy  (in_rdy),
    .mux_en  (mux_en),
    .mux_sel (mux_sel),
    .out_rdy (out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr    = 0;
    m_owner  = 0;
    m_locked = 0;
    m_en     = 0;
    m_sel    = 4'b0;
  endtask

  // Winning source under the arbitration rules, or -1 for no winner.
  function automatic int model_winner();
    if (m_locked) return in_vld[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      if (in_vld[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic bit model_accept();
    return !m_en || out_rdy;
  endfunction

  task automatic model_update(input int w, input bit acc);
    if (acc && w >= 0) begin
      m_en  = 1;
      m_sel = 4'(1 << w);
      if (in_last[w]) begin
        m_locked = 0;
        m_ptr    = (w + 1) % N;
      end else begin
        m_locked = 1;
        m_owner  = w;
      end
    end else if (acc) begin
      m_en  = 0;
      m_sel = 4'b0;
    end
  endtask

  // One clock cycle with the inputs as currently driven. in_rdy is checked
  // before the edge, and the registered outputs after it.
  task automatic step();
    int w;
    bit acc;
    logic [3:0] er;
    #1;
    w   = model_winner();
    acc = model_accept();
    er  = (acc && w >= 0) ? 4'(1 << w) : 4'b0;
    chk("in_rdy", {28'b0, in_rdy}, {28'b0, er});
    chk("rdy_onehot0", {31'b0, $onehot0(in_rdy)}, 32'd1);
    @(posedge clk);
    model_update(w, acc);
    #1;
    chk("mux_en", {31'b0, mux_en}, {31'b0, m_en});
    chk("mux_sel", {28'b0, mux_sel}, {28'b0, m_sel});
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic r);
    in_vld  = v;
    in_last = l;
    out_rdy = r;
  endtask

  // Assert reset between clock edges, check the immediate effect, then release.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mux_en", {31'b0, mux_en}, 32'd0);
    chk("rst_mux_sel", {28'b0, mux_sel}, 32'd0);
    chk("rst_in_rdy", {28'b0, in_rdy}, 32'd0);
    model_reset();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    drive(4'b1111, 4'b1111, 1'b1);

    // Reset state with every source requesting
    #1;
    chk("reset_in_rdy", {28'b0, in_rdy}, 32'd0);
    chk("reset_mux_en", {31'b0, mux_en}, 32'd0);
    chk("reset_mux_sel", {28'b0, mux_sel}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Round-robin fairness: 8 single-beat packets, no idle cycles
    for (int i = 0; i < 8; i++) begin
      step();
      chk("fair_sel", {28'b0, mux_sel}, 32'(1 << (i % 4)));
      chk("fair_en", {31'b0, mux_en}, 32'd1);
    end

    // Locking: source 2 sends a 3-beat packet while the others are valid
    drive(4'b0100, 4'b0000, 1'b1); step();
    chk("lock_b1", {28'b0, mux_sel}, 32'b0100);
    drive(4'b1111, 4'b0000, 1'b1); step();
    chk("lock_b2", {28'b0, mux_sel}, 32'b0100);
    drive(4'b1111, 4'b0100, 1'b1); step();
    chk("lock_b3", {28'b0, mux_sel}, 32'b0100);
    drive(4'b1111, 4'b1111, 1'b1); step();
    chk("lock_next", {28'b0, mux_sel}, 32'b1000);

    // Owner stall: source 1 locked, then idle while source 0 waits
    drive(4'b0010, 4'b0000, 1'b1); step();
    chk("stall_lock", {28'b0, mux_sel}, 32'b0010);
    drive(4'b0001, 4'b0001, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_en", {31'b0, mux_en}, 32'd0);
    end
    drive(4'b0011, 4'b0010, 1'b1); step();
    chk("stall_last", {28'b0, mux_sel}, 32'b0010);
    drive(4'b0001, 4'b0001, 1'b1); step();
    chk("stall_then0", {28'b0, mux_sel}, 32'b0001);

    // Backpressure: hold 0010 for 5 cycles, then reload in the same cycle
    drive(4'b1111, 4'b1111, 1'b1); step();
    chk("bp_load", {28'b0, mux_sel}, 32'b0010);
    drive(4'b1111, 4'b1111, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold", {28'b0, mux_sel}, 32'b0010);
    end
    drive(4'b1111, 4'b1111, 1'b1);
    #1 chk("bp_rdy", {28'b0, in_rdy}, 32'b0100);
    step();
    chk("bp_next", {28'b0, mux_sel}, 32'b0100);

    // Wrap from 3 to 0, then async reset in the middle of a source 1 packet
    drive(4'b1000, 4'b1000, 1'b1); step();
    chk("wrap_3", {28'b0, mux_sel}, 32'b1000);
    drive(4'b0001, 4'b0001, 1'b1); step();
    chk("wrap_0", {28'b0, mux_sel}, 32'b0001);
    drive(4'b0010, 4'b0000, 1'b1); step();
    drive(4'b0010, 4'b0000, 1'b1); step();
    async_reset();
    drive(4'b1111, 4'b1111, 1'b1); step();
    chk("post_rst", {28'b0, mux_sel}, 32'b0001);

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      drive(4'($urandom), 4'($urandom & $urandom), $urandom_range(0, 3) != 0);
      step();
      if ($urandom_range(0, 99) == 0) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/tt_dfd_rr_onehot_arbiter.md
# tt_dfd_rr_onehot_arbiter

Round-robin, packet-locking arbiter that produces the registered one-hot select and enable consumed directly by the downstream decoded mux. It takes valid/last/ready handshakes from NUM_REQ debug-trace sources and picks one source per beat. It holds the grant for the whole of a multi-beat packet. It presents the winner through a one-entry output register, so `mux_sel` is always one-hot whenever `mux_en` is high.

## Interface
- NUM_REQ, default 4: number of requesting sources; must be ≥ 2.
- PTR_W, default $clog2(NUM_REQ): width of the priority pointer (derived; do not override).

- clk  input  1  clock
- rst_n  input  1  reset; asynchronous assert, active-low
- in_vld  input  NUM_REQ  per-source beat valid
- in_last  input  NUM_REQ  per-source final beat of packet; sampled only with in_vld
- in_rdy  output  NUM_REQ  per-source accept; at most one bit high
- mux_en  output  1  registered: output register holds a beat
- mux_sel  output  NUM_REQ  registered one-hot source index of the held beat; all-zero when mux_en=0
- out_rdy  input  1  downstream consumes the held beat this cycle

## Operation
- Reset values:
  - mux_en=0, mux_sel=0
  - ptr=0, lock_owner=0
  - state=IDLE
  - in_rdy=0 while rst_n=0
- The output register frees a slot this cycle when: `accept = !mux_en || out_rdy`.
- Winner selection, IDLE:
  - Winner is the first i with in_vld[i]=1, scanning ptr, ptr+1, … modulo NUM_REQ.
  - No requester means no winner.
- Winner selection, LOCKED: the only candidate is lock_owner, and only if in_vld[lock_owner]=1.
- in_rdy[i] = accept && (i == winner). It is combinational from in_vld, state and out_rdy.
- A beat is taken from source w when in_vld[w] && in_rdy[w]. On that cycle:
  - mux_en ← 1 and mux_sel ← onehot(w).
  - If in_last[w]=0: state ← LOCKED, lock_owner ← w.
  - If in_last[w]=1: state ← IDLE, ptr ← (w+1) mod NUM_REQ. Wrap from NUM_REQ-1 gives 0.
- If accept=1 and no beat is taken: mux_en ← 0, mux_sel ← 0.
- If accept=0: mux_en and mux_sel hold.
- The pointer advances only on a last beat. Mid-packet beats never move ptr.
- If the locked owner drops in_vld:
  - No other source is granted. The arbiter stays LOCKED with no timeout.
  - The output register drains normally.
- A single-beat packet (in_last=1 on the first beat) never enters LOCKED.
- Reset asserted mid-packet: everything returns to reset values immediately (async). The partial packet is abandoned; no state is retained.
- Reset deassertion: the first grant can occur in the first clock edge after rst_n rises.

## Timing
- Latency is 1 cycle: a beat taken at edge k shows mux_en=1 and mux_sel after edge k.
- Throughput is one beat per cycle while out_rdy=1. A back-to-back change of winner costs no bubble.
- out_rdy=0 with mux_en=1 stalls the block:
  - in_rdy stays all-zero.
  - mux_sel is stable.
- Simultaneous drain and fill (mux_en=1, out_rdy=1, winner present) reloads the output register in the same cycle.
- Invariant: in_rdy is at most one-hot.
- Invariant: mux_sel is one-hot whenever mux_en=1, and zero otherwise.
- Invariant: mux_sel never changes while mux_en && !out_rdy.

## Test plan
All scenarios use NUM_REQ=4.
- Reset check: hold rst_n=0 with in_vld=4'b1111 -> in_rdy=0, mux_en=0, mux_sel=0. On release with out_rdy=1, the first grant is source 0 and mux_sel=4'b0001 one cycle later.
- Round-robin fairness: in_vld=4'b1111, in_last=4'b1111, out_rdy=1 for 8 cycles -> mux_sel sequence 0001,0010,0100,1000,0001,0010,0100,1000 with no idle cycles.
- Locking: source 2 sends a 3-beat packet (last on beat 3) while sources 0, 1 and 3 are valid -> mux_sel=0100 for 3 consecutive cycles, then 1000 (ptr=3).
- Owner stall: source 1 is locked and drops in_vld for 4 cycles while source 0 is valid -> in_rdy=0, mux_en drops to 0 after one cycle, and source 0 is never granted until source 1 sends its last beat.
- Backpressure: mux_en=1, mux_sel=0010, out_rdy=0 for 5 cycles with all sources valid -> mux_sel is stable and in_rdy=0. On out_rdy=1, the next winner is source 2 in the same cycle.
- Wrap and async reset: source 3 single beat, then source 0 -> ptr goes 0→… Assert rst_n low mid-packet (locked on source 1) between clock edges -> mux_en=0 immediately. After release, grant order restarts at source 0.
